// File: rtl/stack_buffer.sv
// -----------------------------------------------------------------------------
// stack_buffer
//   LIFO stack of DEPTH = 2**ADDR_WIDTH words. It is driven by single-cycle
//   push/pop ticks. The top of stack is readable combinationally. Rejected
//   requests raise a one-cycle error pulse.
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  log2 of the stack depth
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   push    in   push request tick
//   pop     in   pop request tick
//   w_data  in   word written on an accepted push or replace
//   r_data  out  top-of-stack word, zero when empty
//   count   out  number of valid entries, 0..DEPTH
//   empty   out  count == 0
//   full    out  count == DEPTH
//   ovf     out  one-cycle pulse: push rejected while full
//   udf     out  one-cycle pulse: pop rejected while empty
// -----------------------------------------------------------------------------
module stack_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  udf
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SpFull = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SpOne  = (ADDR_WIDTH + 1)'(1);

  // State
  logic [ADDR_WIDTH:0]   r_sp;
  logic                  r_ovf;
  logic                  r_udf;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Decodes and next-state
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_replace;
  logic                  w_ovf_next;
  logic                  w_udf_next;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_top_idx;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH:0]   w_sp_next;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SpFull);
  // Index of the top entry; only meaningful when not empty.
  assign w_top_idx = ADDR_WIDTH'(r_sp - SpOne);

  always_comb begin
    w_replace  = 1'b0;
    w_push_acc = 1'b0;
    w_pop_acc  = 1'b0;
    w_ovf_next = 1'b0;
    w_udf_next = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_idx   = r_sp[ADDR_WIDTH-1:0];
    w_sp_next  = r_sp;

    // Simultaneous push and pop on a non-empty stack overwrites the top in
    // place; on an empty stack it degenerates to a plain push.
    w_replace  = push & pop & ~w_empty;
    w_push_acc = push & ~w_full & (~pop | w_empty);
    w_pop_acc  = pop & ~push & ~w_empty;
    w_ovf_next = push & ~pop & w_full;
    w_udf_next = pop & ~push & w_empty;

    w_wr_en = w_push_acc | w_replace;
    if (w_replace) begin
      w_wr_idx = w_top_idx;
    end

    if (w_push_acc) begin
      w_sp_next = r_sp + SpOne;
    end else if (w_pop_acc) begin
      w_sp_next = r_sp - SpOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_sp  <= w_sp_next;
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
    end
  end

  // Storage is not reset; empty masks stale contents on r_data. Writes are
  // suppressed while rst is low so requests during reset have no effect.
  always_ff @(posedge clk) begin
    if (w_wr_en && rst) begin
      r_mem[w_wr_idx] <= w_data;
    end
  end

  assign r_data = w_empty ? '0 : r_mem[w_top_idx];
  assign count  = r_sp;
  assign empty  = w_empty;
  assign full   = w_full;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

// File: tb/tb_stack_buffer.sv
// -----------------------------------------------------------------------------
// tb_stack_buffer
//   Self-checking bench for stack_buffer using default parameters. A small
//   behavioural stack model predicts the outputs for each cycle. The
//   predictions are queued when stimulus is driven, then popped and compared
//   after the clock edge.
// -----------------------------------------------------------------------------
module tb_stack_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  stack_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .w_data(w_data),
    .r_data(r_data),
    .count (count),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .udf   (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   count;
    logic [DW-1:0] data;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int            m_sp;
  logic [DW-1:0] m_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_outputs(input logic o, input logic u);
    exp_t e;
    e.count = (AW + 1)'(m_sp);
    e.data  = (m_sp == 0) ? '0 : m_mem[m_sp-1];
    e.empty = (m_sp == 0);
    e.full  = (m_sp == DEPTH);
    e.ovf   = o;
    e.udf   = u;
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check_eq({tag, ".count"}, 32'(count), 32'(e.count));
    check_eq({tag, ".r_data"}, 32'(r_data), 32'(e.data));
    check_eq({tag, ".empty"}, 32'(empty), 32'(e.empty));
    check_eq({tag, ".full"}, 32'(full), 32'(e.full));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    check_eq({tag, ".udf"}, 32'(udf), 32'(e.udf));
  endtask

  // One clock cycle: drive on the falling edge, predict, sample 1 after rise.
  task automatic cycle(input string tag, input logic p, input logic q, input logic [DW-1:0] d);
    logic o;
    logic u;
    exp_t e;
    @(negedge clk);
    push   = p;
    pop    = q;
    w_data = d;
    o = 1'b0;
    u = 1'b0;
    if (p && q) begin
      if (m_sp == 0) begin
        m_mem[0] = d;
        m_sp     = 1;
      end else begin
        m_mem[m_sp-1] = d;
      end
    end else if (p) begin
      if (m_sp == DEPTH) o = 1'b1;
      else begin
        m_mem[m_sp] = d;
        m_sp++;
      end
    end else if (q) begin
      if (m_sp == 0) u = 1'b1;
      else m_sp--;
    end
    sb_q.push_back(model_outputs(o, u));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_outputs(tag, e);
  endtask

  initial begin
    push   = 1'b0;
    pop    = 1'b0;
    w_data = '0;
    m_sp   = 0;
    rst    = 1'b0;
    #12;
    compare_outputs("reset", model_outputs(1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Three pushes, then drain and underflow
    cycle("push11", 1, 0, 8'h11);
    cycle("push22", 1, 0, 8'h22);
    cycle("push33", 1, 0, 8'h33);
    cycle("pop1", 0, 1, 8'h00);
    cycle("pop2", 0, 1, 8'h00);
    cycle("pop3", 0, 1, 8'h00);
    cycle("pop_udf", 0, 1, 8'h00);
    cycle("idle_after_udf", 0, 0, 8'h00);

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, DW'(i));
    cycle("push_ovf", 1, 0, 8'hAA);
    cycle("idle_after_ovf", 0, 0, 8'h00);

    // Replace at count 2, then at full
    for (int i = 0; i < DEPTH - 2; i++) cycle("drain_to2", 0, 1, 8'h00);
    cycle("replace_c2", 1, 1, 8'h55);
    cycle("idle_c2", 0, 0, 8'h00);
    for (int i = 0; i < DEPTH - 2; i++) cycle("refill", 1, 0, DW'(8'hC0 + i));
    cycle("replace_full", 1, 1, 8'h66);
    cycle("idle_full", 0, 0, 8'h00);

    // Push and pop together while empty
    for (int i = 0; i < DEPTH; i++) cycle("drain_all", 0, 1, 8'h00);
    cycle("pushpop_empty", 1, 1, 8'h77);
    cycle("idle_empty_pp", 0, 0, 8'h00);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      cycle("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            DW'($urandom_range(0, 255)));
    end

    // Asynchronous reset with count 5, push held across release
    while (m_sp < 5) cycle("to5", 1, 0, DW'(8'h40 + m_sp));
    while (m_sp > 5) cycle("to5", 0, 1, 8'h00);
    cycle("at5", 0, 0, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b0;
    m_sp = 0;
    #1;
    compare_outputs("async_rst", model_outputs(1'b0, 1'b0));
    push   = 1'b1;
    pop    = 1'b0;
    w_data = 8'h99;
    @(posedge clk);
    #1;
    compare_outputs("push_in_rst", model_outputs(1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    m_mem[0] = 8'h99;
    m_sp     = 1;
    @(posedge clk);
    #1;
    compare_outputs("push_after_rel", model_outputs(1'b0, 1'b0));
    push = 1'b0;
    cycle("idle_end", 0, 0, 8'h00);

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_buffer.md
STACK_BUFFER -- requirements
Module: stack_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  one-cycle push request; edge_detector tick from the push button.
REQ-006 pop  input  1  one-cycle pop request; edge_detector tick from the pop button.
REQ-007 w_data  input  DATA_WIDTH  word written on an accepted push.
REQ-008 r_data  output  DATA_WIDTH  current top-of-stack word.
REQ-009 count  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
REQ-010 empty  output  1  high when count == 0.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 ovf  output  1  one-cycle pulse: push rejected because the stack is full.
REQ-013 udf  output  1  one-cycle pulse: pop rejected because the stack is empty.

Function
REQ-014 The block SHALL hold a stack pointer sp (ADDR_WIDTH+1 bits) equal to count; the top entry is mem[sp-1].
REQ-015 Push only, not full: mem[sp] <= w_data and sp <= sp+1 at the clock edge.
REQ-016 Pop only, not empty: sp <= sp-1; memory contents are unchanged.
REQ-017 Push only while full: no state change except ovf = 1 for exactly the next cycle.
REQ-018 Pop only while empty: no state change except udf = 1 for exactly the next cycle.
REQ-019 Push and pop together, not empty: the top is replaced, mem[sp-1] <= w_data; sp is unchanged; no error pulse, including when full.
REQ-020 Push and pop together while empty: treated as push only; sp <= 1; no udf.
REQ-021 r_data SHALL be combinational from mem[sp-1] when not empty, and all-zero when empty.
REQ-022 empty, full and count SHALL be combinational decodes of sp, reflecting the new value in the cycle after an accepted operation.
REQ-023 ovf and udf SHALL be registered, asserting the cycle after the offending request; they are never high together.
REQ-024 Requests SHALL be sampled every cycle with no latency beyond one clock; back-to-back pushes or pops on consecutive cycles are all honoured.
REQ-025 sp SHALL never wrap: never above DEPTH, never below 0.

Reset
REQ-026 When rst is low, sp, ovf and udf SHALL clear immediately, regardless of clk.
REQ-027 During reset: count = 0, empty = 1, full = 0, r_data = 0, ovf = 0, udf = 0.
REQ-028 Memory contents need not be cleared; they are unreadable until rewritten because empty masks r_data.
REQ-029 Reset asserted mid-operation SHALL abort any request in that cycle; the first operation honoured is on the first rising edge after rst returns high.
REQ-030 push and pop are ignored while rst is low.

Verification
REQ-031 Reset, then push 0x11, 0x22, 0x33 on three consecutive cycles -> count = 3, r_data = 0x33, empty = 0.
REQ-032 From REQ-031, pop three times -> r_data goes 0x22, 0x11, then 0x00 with empty = 1; a fourth pop -> udf pulses one cycle, count stays 0.
REQ-033 Push 16 words 0x00..0x0F (defaults) -> full = 1, r_data = 0x0F; push 0xAA -> ovf pulses one cycle, r_data stays 0x0F, count stays 16.
REQ-034 Push and pop together with w_data = 0x55 at count = 2 -> count stays 2, r_data = 0x55, no error pulse; repeat while full -> count stays 16, no ovf.
REQ-035 Push and pop together while empty with w_data = 0x77 -> count = 1, r_data = 0x77, udf stays 0.
REQ-036 Drive rst low between clock edges with count = 5 -> count = 0, empty = 1 immediately; a push held across release is honoured only from the first edge after release.
